// File: rtl/disk_stream_ctrl.sv
// Runs a sequence of k values through an external disk core, one at a time, and
// streams the points out of a first-word-fall-through FIFO. Defining
// DISK_STREAM_ABORT_EN adds the cfg_abort input and its abort handling.
module disk_stream_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [31:0] cfg_seed,
  input  logic [15:0] cfg_count,
  input  logic [1:0]  cfg_base_sel0,
  input  logic [1:0]  cfg_base_sel1,
`ifdef DISK_STREAM_ABORT_EN
  input  logic        cfg_abort,
`endif
  output logic        busy,
  output logic        run_done,
  output logic        core_start,
  output logic [31:0] core_k,
  output logic [1:0]  core_base_sel0,
  output logic [1:0]  core_base_sel1,
  input  logic        core_ready,
  input  logic        core_done,
  input  logic [31:0] core_x,
  input  logic [31:0] core_y,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_x,
  output logic [31:0] m_y,
  output logic        m_last
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        last;
  } beat_t;

  state_t        state, state_nx;
  logic [31:0]   k_q;
  logic [15:0]   remaining;
  logic [1:0]    sel0_q, sel1_q;
  beat_t         mem [FIFO_DEPTH];
  beat_t         head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          load, issue, push, pop, finish, flush;

`ifdef DISK_STREAM_ABORT_EN
  logic          abort_pend;
`endif

  assign busy           = (state != IDLE);
  assign core_k         = k_q;
  assign core_base_sel0 = sel0_q;
  assign core_base_sel1 = sel1_q;

  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  assign head    = mem[rd_ptr];
  // Gate the head entry so the unreset storage never shows through when empty.
  assign m_x     = m_valid ? head.x    : '0;
  assign m_y     = m_valid ? head.y    : '0;
  assign m_last  = m_valid ? head.last : 1'b0;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_nx = state;
    load     = 1'b0;
    issue    = 1'b0;
    push     = 1'b0;
    finish   = 1'b0;
    flush    = 1'b0;
    case (state)
      IDLE:  if (cfg_start && cfg_count != '0) begin
               load     = 1'b1;
               state_nx = ISSUE;
             end
      ISSUE: if (core_ready && occ < FULL_OCC) begin
               issue    = 1'b1;
               state_nx = WAIT;
             end
      WAIT:  if (core_done) begin
               push     = 1'b1;
               state_nx = (remaining == 16'd1) ? FLUSH : ISSUE;
             end
      FLUSH: if (pop && head.last) begin
               finish   = 1'b1;
               state_nx = IDLE;
             end
      default: state_nx = IDLE;
    endcase
`ifdef DISK_STREAM_ABORT_EN
    // An abort in WAIT is deferred until the in-flight result comes back and is dropped.
    if ((state == ISSUE || state == FLUSH) && cfg_abort) begin
      issue    = 1'b0;
      finish   = 1'b0;
      flush    = 1'b1;
      state_nx = IDLE;
    end
    if (state == WAIT && core_done && (cfg_abort || abort_pend)) begin
      push     = 1'b0;
      flush    = 1'b1;
      state_nx = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= IDLE;
      k_q        <= '0;
      remaining  <= '0;
      sel0_q     <= '0;
      sel1_q     <= '0;
      core_start <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      state      <= state_nx;
      core_start <= issue;
      run_done   <= finish;
      if (load) begin
        k_q       <= cfg_seed;
        remaining <= cfg_count;
        sel0_q    <= cfg_base_sel0;
        sel1_q    <= cfg_base_sel1;
      end
      if (push) begin
        k_q       <= k_q + 32'd1;
        remaining <= remaining - 16'd1;
      end
    end
  end

`ifdef DISK_STREAM_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) abort_pend <= 1'b0;
    else        abort_pend <= (state == WAIT) && !core_done && (abort_pend || cfg_abort);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{x: core_x, y: core_y, last: (remaining == 16'd1)};
  end

endmodule

// File: tb/tb_disk_stream_ctrl.sv
// Self-checking bench for disk_stream_ctrl: a behavioural disk core, a stream
// monitor and an expected-point model built from seed/count arithmetic.
`timescale 1ns/1ps
module tb_disk_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_seed = '0;
  logic [15:0] cfg_count = '0;
  logic [1:0]  cfg_base_sel0 = '0;
  logic [1:0]  cfg_base_sel1 = '0;
`ifdef DISK_STREAM_ABORT_EN
  logic        cfg_abort = 1'b0;
`endif
  logic        busy, run_done, core_start;
  logic [31:0] core_k;
  logic [1:0]  core_base_sel0, core_base_sel1;
  logic        core_ready = 1'b1;
  logic        core_done = 1'b0;
  logic [31:0] core_x = '0;
  logic [31:0] core_y = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_x, m_y;
  logic        m_last;

  always #5 clk = ~clk;

  disk_stream_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_seed(cfg_seed), .cfg_count(cfg_count),
    .cfg_base_sel0(cfg_base_sel0), .cfg_base_sel1(cfg_base_sel1),
`ifdef DISK_STREAM_ABORT_EN
    .cfg_abort(cfg_abort),
`endif
    .busy(busy), .run_done(run_done), .core_start(core_start), .core_k(core_k),
    .core_base_sel0(core_base_sel0), .core_base_sel1(core_base_sel1),
    .core_ready(core_ready), .core_done(core_done), .core_x(core_x), .core_y(core_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_last(m_last)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        last;
  } beat_t;

  int n_cmp = 0;
  int n_bad = 0;

  // The disk core's "answer" for a k: any fixed function of k and base select works.
  function automatic logic [31:0] px(input logic [31:0] k, input logic [1:0] s);
    return (k * 32'd2654435761) ^ {30'd0, s};
  endfunction
  function automatic logic [31:0] py(input logic [31:0] k, input logic [1:0] s);
    return ~k ^ {s, 30'd0};
  endfunction

  // Disk core model: one op at a time, fixed or random latency, checks held inputs.
  int          core_lat = 5;
  bit          core_lat_rand = 1'b0;
  bit          core_pending = 1'b0;
  int          core_wait = 0;
  logic [31:0] cap_k = '0;
  logic [1:0]  cap_s0 = '0, cap_s1 = '0;
  logic [31:0] start_log[$];
  int          overlap_err = 0, hold_err = 0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (!rst_n) begin
      core_pending = 1'b0;
      core_ready   = 1'b1;
    end else if (core_start) begin
      if (core_pending) overlap_err++;
      start_log.push_back(core_k);
      cap_k        = core_k;
      cap_s0       = core_base_sel0;
      cap_s1       = core_base_sel1;
      core_pending = 1'b1;
      core_ready   = 1'b0;
      core_wait    = core_lat_rand ? int'($urandom_range(0, 5)) : core_lat - 1;
    end else if (core_pending) begin
      if (core_k !== cap_k || core_base_sel0 !== cap_s0 || core_base_sel1 !== cap_s1) hold_err++;
      if (core_wait == 0) begin
        core_done    = 1'b1;
        core_x       = px(cap_k, cap_s0);
        core_y       = py(cap_k, cap_s1);
        core_pending = 1'b0;
        core_ready   = 1'b1;
      end else begin
        core_wait--;
      end
    end
  end

  // Stream side: drives m_ready, records accepted beats, watches stall stability and run_done.
  int          ready_mode = 1;  // 0 = hold off, 1 = always ready, 2 = random
  beat_t       obs_q[$];
  int          done_cnt = 0, stall_err = 0, done_busy_err = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_x = '0, prev_y = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_x !== prev_x || m_y !== prev_y || m_last !== prev_last))
        stall_err++;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_valid && m_ready) obs_q.push_back('{x: m_x, y: m_y, last: m_last});
      prev_stall = m_valid && !m_ready;
      prev_x     = m_x;
      prev_y     = m_y;
      prev_last  = m_last;
      if (run_done) begin
        done_cnt++;
        if (busy) done_busy_err++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    start_log.delete();
    obs_q.delete();
    done_cnt      = 0;
    overlap_err   = 0;
    hold_err      = 0;
    stall_err     = 0;
    done_busy_err = 0;
  endtask

  task automatic start_run(input logic [31:0] seed, input logic [15:0] count,
                           input logic [1:0] s0, input logic [1:0] s1);
    tick();
    cfg_start     = 1'b1;
    cfg_seed      = seed;
    cfg_count     = count;
    cfg_base_sel0 = s0;
    cfg_base_sel1 = s1;
    tick();
    cfg_start     = 1'b0;
    cfg_seed      = $urandom;
    cfg_count     = 16'($urandom);
    cfg_base_sel0 = 2'($urandom);
    cfg_base_sel1 = 2'($urandom);
  endtask

  task automatic wait_starts(input string name, input int n, input int budget);
    int cyc = 0;
    while (start_log.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (start_log.size() < n) begin
      n_bad++;
      $display("FAIL %s start wait: got %0d core_start, need %0d", name, start_log.size(), n);
    end
  endtask

  // Waits for the end of a run and compares everything observed with the model.
  task automatic check_run(input string name, input logic [31:0] seed, input int count,
                           input logic [1:0] s0, input logic [1:0] s1, input int budget);
    int          cyc = 0;
    logic [31:0] ek;
    while (done_cnt == 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (done_cnt == 0) begin
      n_bad++;
      $display("FAIL %s run_done: none within %0d cycles", name, budget);
    end
    repeat (4) tick();
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL %s run_done count: got %0d, need 1", name, done_cnt);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy after run: got %b, need 0", name, busy);
    end
    n_cmp++;
    if (start_log.size() != count) begin
      n_bad++;
      $display("FAIL %s core_start count: got %0d, need %0d", name, start_log.size(), count);
    end
    for (int i = 0; i < count && i < start_log.size(); i++) begin
      ek = seed + 32'(i);
      n_cmp++;
      if (start_log[i] !== ek) begin
        n_bad++;
        $display("FAIL %s core_k[%0d]: got %h, need %h", name, i, start_log[i], ek);
      end
    end
    n_cmp++;
    if (obs_q.size() != count) begin
      n_bad++;
      $display("FAIL %s beat count: got %0d, need %0d", name, obs_q.size(), count);
    end
    for (int i = 0; i < count && i < obs_q.size(); i++) begin
      ek = seed + 32'(i);
      n_cmp++;
      if (obs_q[i].x !== px(ek, s0) || obs_q[i].y !== py(ek, s1) || obs_q[i].last !== (i == count - 1)) begin
        n_bad++;
        $display("FAIL %s beat[%0d]: got x=%h y=%h last=%b, need x=%h y=%h last=%b", name, i,
                 obs_q[i].x, obs_q[i].y, obs_q[i].last, px(ek, s0), py(ek, s1), (i == count - 1));
      end
    end
    n_cmp++;
    if (overlap_err + hold_err + stall_err + done_busy_err != 0) begin
      n_bad++;
      $display("FAIL %s protocol: overlap=%0d hold=%0d stall=%0d done_with_busy=%0d, need all 0",
               name, overlap_err, hold_err, stall_err, done_busy_err);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [106:0] outs;
    outs = {busy, run_done, core_start, core_k, core_base_sel0, core_base_sel1,
            m_valid, m_x, m_y, m_last};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL %s outputs in reset: got %h, need all 0", name, outs);
    end
  endtask

  task automatic test_reset();
    #1;
    check_outputs_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset release: got busy=%b m_valid=%b, need 0 0", busy, m_valid);
    end
  endtask

  task automatic test_basic();
    clear_logs();
    ready_mode    = 1;
    core_lat      = 5;
    core_lat_rand = 1'b0;
    start_run(32'd1, 16'd3, 2'b00, 2'b01);
    check_run("basic", 32'd1, 3, 2'b00, 2'b01, 200);
  endtask

  task automatic test_backpressure();
    logic [31:0] seed;
    seed = $urandom;
    clear_logs();
    ready_mode = 0;
    core_lat   = 3;
    start_run(seed, 16'd6, 2'b10, 2'b11);
    repeat (60) tick();
    n_cmp++;
    if (start_log.size() != 4) begin
      n_bad++;
      $display("FAIL backpressure stall: got %0d core_start, need 4", start_log.size());
    end
    n_cmp++;
    if (busy !== 1'b1 || m_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure state: got busy=%b m_valid=%b, need 1 1", busy, m_valid);
    end
    ready_mode = 1;
    check_run("backpressure", seed, 6, 2'b10, 2'b11, 300);
  endtask

  task automatic test_k_wrap();
    clear_logs();
    ready_mode = 2;
    core_lat   = 2;
    start_run(32'hFFFF_FFFF, 16'd2, 2'b01, 2'b10);
    check_run("k_wrap", 32'hFFFF_FFFF, 2, 2'b01, 2'b10, 200);
  endtask

  task automatic test_ignored_starts();
    logic [31:0] seed;
    int          busy_cycles = 0;
    clear_logs();
    ready_mode = 1;
    core_lat   = 4;
    start_run(32'h1234_5678, 16'd0, 2'b11, 2'b11);
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0) busy_cycles++;
      tick();
    end
    n_cmp++;
    if (busy_cycles != 0 || start_log.size() != 0 || done_cnt != 0) begin
      n_bad++;
      $display("FAIL count_zero: got busy_cycles=%0d starts=%0d run_done=%0d, need 0 0 0",
               busy_cycles, start_log.size(), done_cnt);
    end
    seed = $urandom;
    start_run(seed, 16'd4, 2'b01, 2'b00);
    wait_starts("start_while_busy", 1, 50);
    cfg_start     = 1'b1;
    cfg_seed      = ~seed;
    cfg_count     = 16'd7;
    cfg_base_sel0 = 2'b11;
    cfg_base_sel1 = 2'b11;
    tick();
    cfg_start = 1'b0;
    check_run("start_while_busy", seed, 4, 2'b01, 2'b00, 300);
  endtask

  task automatic test_reset_mid_run();
    clear_logs();
    ready_mode = 1;
    core_lat   = 8;
    start_run(32'd500, 16'd4, 2'b10, 2'b01);
    wait_starts("mid_reset", 2, 100);
    tick();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    tick();
    check_outputs_zero("mid_reset_hold");
    rst_n = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (done_cnt != 0 || start_log.size() != 2 || m_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset aftermath: got run_done=%0d starts=%0d m_valid=%b busy=%b, need 0 2 0 0",
               done_cnt, start_log.size(), m_valid, busy);
    end
    clear_logs();
    core_lat = 5;
    start_run(32'd10, 16'd1, 2'b00, 2'b00);
    check_run("rerun_after_reset", 32'd10, 1, 2'b00, 2'b00, 100);
  endtask

  task automatic test_random_runs();
    logic [31:0] seed;
    int          count;
    logic [1:0]  s0, s1;
    for (int r = 0; r < 6; r++) begin
      seed  = (r == 0) ? 32'hFFFF_FFF8 : $urandom;
      count = $urandom_range(1, 12);
      s0    = 2'($urandom);
      s1    = 2'($urandom);
      clear_logs();
      ready_mode    = 2;
      core_lat_rand = 1'b1;
      start_run(seed, 16'(count), s0, s1);
      check_run($sformatf("random%0d", r), seed, count, s0, s1, 2000);
    end
    core_lat_rand = 1'b0;
  endtask

`ifdef DISK_STREAM_ABORT_EN
  task automatic test_abort();
    clear_logs();
    ready_mode = 0;
    core_lat   = 6;
    start_run(32'd77, 16'd5, 2'b01, 2'b01);
    wait_starts("abort", 2, 100);
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    repeat (30) tick();
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done_cnt != 0 || start_log.size() != 2 || core_pending) begin
      n_bad++;
      $display("FAIL abort: got m_valid=%b busy=%b run_done=%0d starts=%0d pending=%b, need 0 0 0 2 0",
               m_valid, busy, done_cnt, start_log.size(), core_pending);
    end
    clear_logs();
    ready_mode = 1;
    start_run(32'd200, 16'd2, 2'b11, 2'b00);
    check_run("after_abort", 32'd200, 2, 2'b11, 2'b00, 200);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_k_wrap();
    test_ignored_starts();
    test_reset_mid_run();
    test_random_runs();
`ifdef DISK_STREAM_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disk_stream_ctrl.md
DISK_STREAM_CTRL -- requirements
Module: disk_stream_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle run request.
- cfg_seed  in  32  first k of the run.
- cfg_count  in  16  number of points in the run.
- cfg_base_sel0  in  2  x-axis base select.
- cfg_base_sel1  in  2  y-axis base select.
- busy  out  1  run in progress.
- run_done  out  1  one-cycle end-of-run pulse.
- core_start  out  1  start pulse to disk core.
- core_k  out  32  k to disk core.
- core_base_sel0  out  2  base select to disk core.
- core_base_sel1  out  2  base select to disk core.
- core_ready  in  1  disk core idle.
- core_done  in  1  disk core result valid.
- core_x  in  32  disk core x result.
- core_y  in  32  disk core y result.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream accepts beat.
- m_x  out  32  point x.
- m_y  out  32  point y.
- m_last  out  1  final point of the run.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, FLUSH.
REQ-004 IDLE: cfg_start=1 with cfg_count!=0 SHALL latch seed, count and base selects, go ISSUE and raise busy next cycle; cfg_count=0 SHALL be ignored with no run_done.
REQ-005 cfg_start outside IDLE SHALL be ignored.
REQ-006 ISSUE: when core_ready=1 and FIFO occupancy < FIFO_DEPTH, SHALL drive registered core_start high for exactly one cycle and go WAIT; otherwise SHALL stay in ISSUE.
REQ-007 core_k and core_base_sel0/1 SHALL be stable from core_start through acceptance of the matching core_done.
REQ-008 WAIT: on the first cycle core_done=1, SHALL push {core_x, core_y, last} into the FIFO, increment k modulo 2^32, decrement remaining count, then go ISSUE if remaining!=0, else FLUSH.
REQ-009 At most one core operation SHALL be outstanding at any time.
REQ-010 k wrap: 32'hFFFFFFFF SHALL be followed by 32'h00000000.
REQ-011 The FIFO SHALL be first-word-fall-through: m_valid=1 whenever non-empty; m_x/m_y/m_last come from the head entry; a pushed entry appears on m_* one cycle after the push.
REQ-012 A pop SHALL occur on m_valid&m_ready. Same-cycle push and pop SHALL both take effect with occupancy unchanged.
REQ-013 m_* SHALL hold stable while m_valid=1 and m_ready=0.
REQ-014 FLUSH: when the last beat is popped, SHALL pulse run_done for one cycle, drop busy in the same cycle and return to IDLE.

Reset
REQ-015 rst_n=0 SHALL immediately force IDLE, empty the FIFO and drive busy, run_done, core_start, core_k, core_base_sel0/1, m_valid, m_x, m_y and m_last to 0.
REQ-016 Reset mid-run SHALL discard all pending and in-flight points; no run_done SHALL follow.

Configuration
REQ-017 With DISK_STREAM_ABORT_EN defined, SHALL add input cfg_abort (1 bit). cfg_abort=1 in ISSUE or FLUSH SHALL empty the FIFO and go IDLE. In WAIT it SHALL wait for core_done, discard that result, empty the FIFO and go IDLE. busy SHALL drop on entering IDLE and no run_done SHALL be pulsed.
REQ-018 Without DISK_STREAM_ABORT_EN, cfg_abort and all abort logic SHALL be absent.

Verification
REQ-019 seed=1, count=3, sel0=00, sel1=01, m_ready=1, core model with 5-cycle latency -> core_k 1,2,3 in order, 3 beats, m_last only on the 3rd, one run_done, busy low afterwards.
REQ-020 FIFO_DEPTH=4, count=6, m_ready=0 -> exactly 4 core_start then stall in ISSUE; set m_ready=1 -> remaining 2 issued, 6 beats total in k order.
REQ-021 seed=32'hFFFFFFFF, count=2 -> core_k 32'hFFFFFFFF then 32'h00000000.
REQ-022 count=0 -> no core_start, busy stays 0, no run_done; cfg_start while busy -> no effect on the running sequence.
REQ-023 rst_n low during WAIT of point 2 of 4 -> all outputs 0 within reset, FIFO empty; new run seed=10, count=1 after reset -> single beat from k=10.
REQ-024 With DISK_STREAM_ABORT_EN: abort in WAIT at point 2 of 5 -> core_done absorbed, m_valid=0, busy=0, no run_done, no further core_start.
